ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset input SHALL exist.
REQ-002 Parameter CLK_FREQ_HZ, default 50_000_000, SHALL give the system clock frequency in Hz.
REQ-003 Parameter INHIBIT_CYCLES, default 5000, SHALL set the clock-inhibit hold, 100 us at 50 MHz.
REQ-004 Parameter TIMEOUT_CYCLES, default 100000, SHALL set the maximum wait for any device clock edge, 2 ms at 50 MHz.
REQ-005 clk  input  1  system clock; all state SHALL change only on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 tx_valid  input  1  request to send tx_byte.
REQ-008 tx_byte  input  8  command byte to the keyboard, for example 0xED to set LEDs.
REQ-009 tx_ready  output  1  high when a request can be accepted; equal to !busy.
REQ-010 busy  output  1  high from acceptance until done or error.
REQ-011 done  output  1  one-cycle pulse when the device acknowledges the byte.
REQ-012 error  output  1  one-cycle pulse on timeout or missing ACK.
REQ-013 PS2KeyboardClk  input  1  raw PS/2 clock line, asynchronous.
REQ-014 PS2KeyboardData  input  1  raw PS/2 data line, asynchronous.
REQ-015 ps2_clk_oe  output  1  when 1, the block drives the PS/2 clock line low; when 0, it releases the line (open-drain).
REQ-016 ps2_data_oe  output  1  when 1, the block drives the PS/2 data line low; when 0, it releases the line (open-drain).

Function
REQ-017 Both PS/2 inputs SHALL pass through a 2-FF synchronizer. A device falling edge SHALL be detected when the previous synchronized clock was 1 and the current one is 0.
REQ-018 A request SHALL be accepted only in the cycle where tx_valid and tx_ready are both high. The block SHALL latch tx_byte and parity = ~^tx_byte (odd parity) in that cycle.
REQ-019 tx_valid while busy SHALL be ignored; no queueing.
REQ-020 States: IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-021 IDLE -> INHIBIT on acceptance. ps2_clk_oe SHALL be 1 from the next cycle for exactly INHIBIT_CYCLES cycles.
REQ-022 INHIBIT -> START: ps2_data_oe SHALL go to 1 one cycle before ps2_clk_oe goes to 0, giving the request-to-send (start bit).
REQ-023 START -> DATA on the 1st falling edge. On falling edges 1..8, ps2_data_oe SHALL become the inverse of data bits 0..7, LSB first.
REQ-024 On falling edge 9 the block SHALL present the parity bit.
REQ-025 On falling edge 10 the block SHALL release data (stop bit = 1).
REQ-026 In ACK, on falling edge 11 the block SHALL sample data. A value of 0 SHALL go to WAIT_IDLE. A value of 1 SHALL pulse error and go to IDLE.
REQ-027 WAIT_IDLE -> IDLE SHALL occur when the synchronized clock and data are both 1. done SHALL pulse in that same cycle.
REQ-028 An edge-gap counter SHALL clear on every falling edge and in IDLE/INHIBIT. If it reaches TIMEOUT_CYCLES in START..WAIT_IDLE, the block SHALL release both lines, pulse error and go to IDLE.
REQ-029 done and error SHALL never be high in the same cycle.
REQ-030 tx_ready SHALL be high again in the cycle after the done or error pulse.
REQ-031 Counter widths SHALL be $clog2 of their parameter plus 1. The bit index SHALL be 4 bits, counting 0..11 with no wrap.

Reset
REQ-032 Reset SHALL force asynchronously: state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0, all counters and the shift register = 0.
REQ-033 Reset mid-transfer SHALL release both lines immediately and SHALL NOT produce a done or error pulse.

Structure
REQ-034 Package ps2_pkg SHALL hold the state enumeration, the frame-length constant (11) and the default timing constants. The existing receiver SHALL reuse the package.
REQ-035 A sub-module ps2_line_sync SHALL contain the synchronizers and the falling-edge detector. It SHALL be shared with the receiver.

Verification
REQ-036 tx_byte=0xED with an ACKing device model -> the device samples 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; error stays 0.
REQ-037 tx_byte=0x01 -> parity bit 0; clock held low for exactly 5000 cycles before release.
REQ-038 Device model leaves data high on edge 11 -> one error pulse, no done, both oe = 0, tx_ready = 1.
REQ-039 Device model stops clocking after edge 4 -> error pulse exactly 100000 cycles after edge 4; lines released.
REQ-040 Reset asserted during DATA -> ps2_clk_oe = ps2_data_oe = 0 with no clock edge; no done or error pulse; the next request completes normally.
REQ-041 tx_valid pulsed with 0x55 while busy sending 0xF4 -> only 0xF4 appears on the line; exactly one done pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame length and default timing constants
package ps2_pkg;
    typedef logic [2:0] ps2_state_t;
    localparam ps2_state_t S_IDLE      = 3'd0;
    localparam ps2_state_t S_INHIBIT   = 3'd1;
    localparam ps2_state_t S_START     = 3'd2;
    localparam ps2_state_t S_DATA      = 3'd3;
    localparam ps2_state_t S_PARITY    = 3'd4;
    localparam ps2_state_t S_STOP      = 3'd5;
    localparam ps2_state_t S_ACK       = 3'd6;
    localparam ps2_state_t S_WAIT_IDLE = 3'd7;
    localparam int FRAME_BITS      = 11;
    localparam int DEF_CLK_FREQ_HZ = 50_000_000;
    localparam int INHIBIT_US      = 100;
    localparam int TIMEOUT_US      = 2000;
    function automatic int us_to_cycles(input int freq_hz, input int us);
        return freq_hz / 1_000_000 * us;
    endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for the PS/2 lines plus device clock falling-edge detect
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_s,
    output logic o_data_s,
    output logic o_fall
);
    logic [2:0] r_clk_pipe;
    logic [1:0] r_data_pipe;
    // idle-high reset values keep reset release from looking like a falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_pipe  <= 3'b111;
            r_data_pipe <= 2'b11;
        end else begin
            r_clk_pipe  <= {r_clk_pipe[1:0], i_ps2_clk};
            r_data_pipe <= {r_data_pipe[0], i_ps2_data};
        end
    end
    assign o_clk_s  = r_clk_pipe[1];
    assign o_data_s = r_data_pipe[1];
    assign o_fall   = r_clk_pipe[2] & ~r_clk_pipe[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with clock inhibit, odd parity, ACK check and timeout
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
    parameter int INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US),
    parameter int TIMEOUT_CYCLES = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US)
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       PS2KeyboardClk,
    input  logic       PS2KeyboardData,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    ps2_state_t r_state;
    logic [IW-1:0] r_inh;
    logic [TW-1:0] r_to;
    logic [3:0] r_bit;
    logic [7:0] r_shift;
    logic r_par, r_busy, r_done, r_err, r_clk_oe, r_data_oe;
    logic w_clk_s, w_data_s, w_fall, w_active, w_timeout;
    ps2_line_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .i_ps2_clk (PS2KeyboardClk),
        .i_ps2_data(PS2KeyboardData),
        .o_clk_s   (w_clk_s),
        .o_data_s  (w_data_s),
        .o_fall    (w_fall)
    );
    assign w_active  = r_state != S_IDLE && r_state != S_INHIBIT;
    assign w_timeout = w_active && !w_fall && r_to == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_inh     <= '0;
            r_to      <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_done || r_err)
                r_busy <= 1'b0;
            r_to <= (!w_active || w_fall) ? '0 : r_to + 1'b1;
            if (w_timeout) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_err     <= 1'b1;
                r_state   <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (tx_valid && !r_busy) begin
                        r_shift  <= tx_byte;
                        r_par    <= ~^tx_byte;
                        r_busy   <= 1'b1;
                        r_clk_oe <= 1'b1;
                        r_inh    <= '0;
                        r_bit    <= '0;
                        r_state  <= S_INHIBIT;
                    end
                    S_INHIBIT: begin
                        r_inh <= r_inh + 1'b1;
                        if (r_inh == IW'(INHIBIT_CYCLES - 2))
                            r_data_oe <= 1'b1;
                        if (r_inh == IW'(INHIBIT_CYCLES - 1)) begin
                            r_clk_oe <= 1'b0;
                            r_state  <= S_START;
                        end
                    end
                    S_START, S_DATA: if (w_fall) begin
                        r_data_oe <= ~r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit     <= r_bit + 4'd1;
                        r_state   <= (r_bit == 4'd7) ? S_PARITY : S_DATA;
                    end
                    S_PARITY: if (w_fall) begin
                        r_data_oe <= ~r_par;
                        r_bit     <= r_bit + 4'd1;
                        r_state   <= S_STOP;
                    end
                    S_STOP: if (w_fall) begin
                        r_data_oe <= 1'b0;
                        r_bit     <= r_bit + 4'd1;
                        r_state   <= S_ACK;
                    end
                    S_ACK: if (w_fall) begin
                        r_bit   <= 4'(FRAME_BITS);
                        r_err   <= w_data_s;
                        r_state <= w_data_s ? S_IDLE : S_WAIT_IDLE;
                    end
                    S_WAIT_IDLE: if (w_clk_s && w_data_s) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
    assign busy        = r_busy;
    assign tx_ready    = !r_busy;
    assign done        = r_done;
    assign error       = r_err;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed scoreboard bench driving an open-drain PS/2 device model
module tb_ps2_host_tx;
    localparam int INH = 50;
    localparam int TO  = 2000;
    localparam int H   = 20;
    typedef struct { logic [7:0] b; logic ack; } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_valid = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic tx_ready, busy, done, error, ps2_clk_oe, ps2_data_oe;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    wire PS2KeyboardClk  = dev_clk & ~ps2_clk_oe;
    wire PS2KeyboardData = dev_data & ~ps2_data_oe;
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int n_done = 0, n_err = 0, n_both = 0;
    exp_t q[$];
    always #5 clk = ~clk;
    ps2_host_tx #(.CLK_FREQ_HZ(50_000_000), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_valid       (tx_valid),
        .tx_byte        (tx_byte),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .PS2KeyboardClk (PS2KeyboardClk),
        .PS2KeyboardData(PS2KeyboardData),
        .ps2_clk_oe     (ps2_clk_oe),
        .ps2_data_oe    (ps2_data_oe)
    );
    always @(negedge clk) begin
        if (done) n_done <= n_done + 1;
        if (error) n_err <= n_err + 1;
        if (done && error) n_both <= n_both + 1;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic send_req(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_byte  = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask
    task automatic wait_inhibit(output int n, output logic d_prev, output logic d_last);
        int t = 0;
        n = 0;
        d_prev = 1'b0;
        d_last = 1'b0;
        while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
        while (ps2_clk_oe && n < INH + 100) begin
            d_prev = d_last;
            d_last = ps2_data_oe;
            n++;
            @(negedge clk);
        end
    endtask
    task automatic dev_frame(input int edges, input logic ack, output logic [9:0] bits);
        bits = '0;
        repeat (H) @(negedge clk);
        for (int e = 1; e <= edges; e++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (e <= 10) bits[e-1] = PS2KeyboardData;
            if (e == 10 && ack) begin
                repeat (H/2) @(negedge clk);
                dev_data = 1'b0;
                repeat (H/2) @(negedge clk);
            end else repeat (H) @(negedge clk);
            if (e == 11) dev_data = 1'b1;
        end
    endtask
    task automatic wait_result(input int d0, input int e0);
        int k = 0;
        while (n_done == d0 && n_err == e0 && k < 300) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
    endtask
    task automatic frame_check(input string tag, input logic [9:0] bits, input int d0, input int e0);
        exp_t x;
        x = q.pop_front();
        chk({tag, "_byte"}, bits[7:0], x.b);
        chk({tag, "_parity"}, bits[8], ($countones(x.b) % 2) == 0);
        chk({tag, "_stop"}, bits[9], 1);
        chk({tag, "_done"}, n_done - d0, x.ack);
        chk({tag, "_error"}, n_err - e0, !x.ack);
        chk({tag, "_ready"}, tx_ready, 1);
        chk({tag, "_oe"}, {ps2_clk_oe, ps2_data_oe}, 0);
    endtask
    initial begin
        int n, d0, e0, k;
        logic dp, dl;
        logic [9:0] bits;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_pulses", {done, error}, 0);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        // 0xED with ACK
        d0 = n_done; e0 = n_err;
        q.push_back('{8'hED, 1'b1});
        send_req(8'hED);
        wait_inhibit(n, dp, dl);
        chk("ed_inhibit_len", n, INH);
        chk("ed_rts_order", {dp, dl}, 2'b01);
        chk("ed_start_bit", ps2_data_oe, 1);
        dev_frame(11, 1'b1, bits);
        wait_result(d0, e0);
        frame_check("ed", bits, d0, e0);
        // 0x01: parity 0, exact inhibit length
        d0 = n_done; e0 = n_err;
        q.push_back('{8'h01, 1'b1});
        send_req(8'h01);
        wait_inhibit(n, dp, dl);
        chk("01_inhibit_len", n, INH);
        dev_frame(11, 1'b1, bits);
        wait_result(d0, e0);
        frame_check("01", bits, d0, e0);
        // missing ACK
        d0 = n_done; e0 = n_err;
        q.push_back('{8'h3C, 1'b0});
        send_req(8'h3C);
        wait_inhibit(n, dp, dl);
        dev_frame(11, 1'b0, bits);
        wait_result(d0, e0);
        frame_check("nack", bits, d0, e0);
        // device stops after edge 4: sync plus edge register add 3 cycles from the line
        d0 = n_done; e0 = n_err;
        send_req(8'hAA);
        wait_inhibit(n, dp, dl);
        dev_frame(3, 1'b0, bits);
        dev_clk = 1'b0;
        k = 0;
        while (!error && k < TO + 100) begin
            @(negedge clk);
            k++;
            if (k == H) dev_clk = 1'b1;
        end
        dev_clk = 1'b1;
        chk("to_delay", k, TO + 3);
        chk("to_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge clk);
        chk("to_ready", tx_ready, 1);
        chk("to_counts", {n_done - d0, n_err - e0}, {32'd0, 32'd1});
        // reset during DATA
        send_req(8'hA5);
        wait_inhibit(n, dp, dl);
        dev_frame(3, 1'b0, bits);
        d0 = n_done; e0 = n_err;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_pulses", {n_done - d0, n_err - e0}, 0);
        chk("rst_mid_ready", tx_ready, 1);
        d0 = n_done; e0 = n_err;
        q.push_back('{8'hED, 1'b1});
        send_req(8'hED);
        wait_inhibit(n, dp, dl);
        chk("post_rst_inhibit", n, INH);
        dev_frame(11, 1'b1, bits);
        wait_result(d0, e0);
        frame_check("post_rst", bits, d0, e0);
        // 0x55 while busy with 0xF4 must be dropped
        d0 = n_done; e0 = n_err;
        q.push_back('{8'hF4, 1'b1});
        send_req(8'hF4);
        repeat (10) @(negedge clk);
        send_req(8'h55);
        wait_inhibit(n, dp, dl);
        dev_frame(11, 1'b1, bits);
        wait_result(d0, e0);
        frame_check("busy_drop", bits, d0, e0);
        repeat (50) @(negedge clk);
        chk("busy_drop_idle", {busy, ps2_clk_oe}, 0);
        chk("busy_drop_once", n_done - d0, 1);
        chk("never_both", n_both, 0);
        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
